// File: rtl/shift_pkg.sv
// shift_pkg: shared modes, burst states and direction codes for the universal shift register
package shift_pkg;
   typedef enum logic [1:0] {HOLD = 2'b00, SHR = 2'b01, SHL = 2'b10, LOAD = 2'b11} mode_t;
   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
   localparam logic DIR_R = 1'b0;
   localparam logic DIR_L = 1'b1;
endpackage

// File: rtl/shift_cell.sv
// shift_cell: one register bit selecting hold, upper neighbour, lower neighbour or load data
module shift_cell
   import shift_pkg::*;
(
   input  logic  clk,
   input  logic  rs,
   input  mode_t sel,
   input  logic  hi,
   input  logic  lo,
   input  logic  ld,
   output logic  q
);
   always_ff @(posedge clk)
      if (rs) q <= 1'b0;
      else    q <= (sel == SHR) ? hi : (sel == SHL) ? lo : (sel == LOAD) ? ld : q;
endmodule

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: universal shift register with an autonomous counted-burst engine
module univ_shift_reg_n
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rs,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] po,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_sat;
   logic             dir_q, dir_nx;
   mode_t            eff;
   logic [WIDTH+1:0] ext;
   always_comb begin
      cnt_sat  = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;
      state_nx = state;
      cnt_nx   = cnt;
      dir_nx   = dir_q;
      eff      = mode_t'(mode);
      case (state)
         IDLE: if (start) begin
            dir_nx   = dir;
            state_nx = (cnt_sat == '0) ? DONE : BURST;
            cnt_nx   = (cnt_sat == '0) ? '0 : cnt_sat - CNT_W'(1);
            eff      = (cnt_sat == '0) ? HOLD : (dir == DIR_L) ? SHL : SHR;
         end
         BURST: begin
            // the edge that finds the counter empty performs no shift and retires to DONE
            eff      = (cnt == '0) ? HOLD : (dir_q == DIR_L) ? SHL : SHR;
            cnt_nx   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
            state_nx = (cnt == '0) ? DONE : BURST;
         end
         DONE: begin
            eff      = HOLD;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rs) begin
         state <= IDLE;
         cnt   <= '0;
         dir_q <= DIR_R;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         dir_q <= dir_nx;
      end
   assign ext = {sin_r, po, sin_l};
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      shift_cell u_cell (
         .clk (clk),
         .rs  (rs),
         .sel (eff),
         .hi  (ext[i+2]),
         .lo  (ext[i]),
         .ld  (pin[i]),
         .q   (po[i])
      );
   end
   assign sout_r = po[0];
   assign sout_l = po[WIDTH-1];
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb_univ_shift_reg_n: directed checks of manual modes, bursts and reset for the 8-bit instance
module tb_univ_shift_reg_n;
   logic       clk = 1'b0;
   logic       rs, sin_r, sin_l, start, dir, sout_r, sout_l, busy, done;
   logic [1:0] mode;
   logic [7:0] pin, po, exp_po;
   logic [3:0] count;
   int         tests = 0;
   int         fails = 0;

   univ_shift_reg_n #(.WIDTH(8)) dut (
      .clk(clk), .rs(rs), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
      .start(start), .dir(dir), .count(count), .po(po), .sout_r(sout_r),
      .sout_l(sout_l), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [7:0] p, input logic b, input logic d);
      chk({tag, " po"}, 32'(po), 32'(p));
      chk({tag, " busy"}, 32'(busy), 32'(b));
      chk({tag, " done"}, 32'(done), 32'(d));
   endtask

   initial begin
      rs = 1'b0; mode = 2'b11; pin = 8'h5A; sin_r = 1'b0; sin_l = 1'b0;
      start = 1'b0; dir = 1'b0; count = 4'd0;
      tick();
      rs = 1'b1; pin = 8'hFF;
      tick(); tick();
      chk3("reset", 8'h00, 1'b0, 1'b0);
      tick();
      chk("reset load blocked", 32'(po), 32'h00);
      rs = 1'b0; pin = 8'hA5;
      tick();
      chk("load", 32'(po), 32'hA5);
      mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold", 32'(po), 32'hA5);
      end
      chk("hold sout_r", 32'(sout_r), 32'd1);
      chk("hold sout_l", 32'(sout_l), 32'd1);
      mode = 2'b10;
      tick();
      chk("shl", 32'(po), 32'h4A);
      chk("shl sout_l", 32'(sout_l), 32'd0);
      chk("shl sout_r", 32'(sout_r), 32'd0);
      mode = 2'b11; pin = 8'h00;
      tick();
      mode = 2'b01; sin_r = 1'b1; exp_po = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_po = {1'b1, exp_po[7:1]};
         chk("shr", 32'(po), 32'(exp_po));
      end
      chk("shr full", 32'(po), 32'hFF);
      // burst right of 3 with LOAD held on mode throughout
      mode = 2'b11; pin = 8'h81; sin_r = 1'b0;
      tick();
      start = 1'b1; dir = 1'b0; count = 4'd3;
      tick(); chk3("br1", 8'h40, 1'b1, 1'b0);
      start = 1'b0;
      tick(); chk3("br2", 8'h20, 1'b1, 1'b0);
      tick(); chk3("br3", 8'h10, 1'b1, 1'b0);
      tick(); chk3("br done", 8'h10, 1'b1, 1'b1);
      mode = 2'b00;
      tick(); chk3("br after", 8'h10, 1'b0, 1'b0);
      tick(); chk3("br after2", 8'h10, 1'b0, 1'b0);
      start = 1'b1; count = 4'd0;
      tick(); chk3("c0", 8'h10, 1'b1, 1'b1);
      start = 1'b0;
      tick(); chk3("c0 after", 8'h10, 1'b0, 1'b0);
      // full-width left burst, then a saturated count that must behave identically
      for (int r = 0; r < 2; r++) begin
         mode = 2'b11; pin = 8'h00;
         tick();
         mode = 2'b00; start = 1'b1; dir = 1'b1; sin_l = 1'b1; count = (r == 0) ? 4'd8 : 4'd15;
         exp_po = 8'h00;
         for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            exp_po = {exp_po[6:0], 1'b1};
            chk3(r == 0 ? "bl8" : "bl sat", exp_po, 1'b1, 1'b0);
         end
         tick(); chk3(r == 0 ? "bl8 done" : "bl sat done", 8'hFF, 1'b1, 1'b1);
         tick(); chk3(r == 0 ? "bl8 idle" : "bl sat idle", 8'hFF, 1'b0, 1'b0);
      end
      mode = 2'b11; pin = 8'h00; sin_l = 1'b0;
      tick();
      mode = 2'b00; start = 1'b1; dir = 1'b0; sin_r = 1'b1; count = 4'd2;
      tick(); chk3("ign1", 8'h80, 1'b1, 1'b0);
      tick(); chk3("ign2", 8'hC0, 1'b1, 1'b0);
      tick(); chk3("ign done", 8'hC0, 1'b1, 1'b1);
      start = 1'b0;
      tick(); chk3("ign idle", 8'hC0, 1'b0, 1'b0);
      tick(); chk3("ign no second", 8'hC0, 1'b0, 1'b0);
      mode = 2'b11; pin = 8'h00;
      tick();
      mode = 2'b00; start = 1'b1; dir = 1'b1; sin_l = 1'b1; count = 4'd8;
      tick(); start = 1'b0;
      chk3("mid1", 8'h01, 1'b1, 1'b0);
      tick(); tick();
      chk3("mid3", 8'h07, 1'b1, 1'b0);
      rs = 1'b1;
      tick(); chk3("mid rst", 8'h00, 1'b0, 1'b0);
      rs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk3("mid quiet", 8'h00, 1'b0, 1'b0);
      end
      start = 1'b1; dir = 1'b0; sin_r = 1'b1; count = 4'd1;
      tick(); chk3("new1", 8'h80, 1'b1, 1'b0);
      start = 1'b0;
      tick(); chk3("new done", 8'h80, 1'b1, 1'b1);
      tick(); chk3("new idle", 8'h80, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
